mod_cache_mux: RTL and testbench

Two-port arbitration mux between two processors (proc1, proc2) and a single shared 16-bit cache port. A select input chooses which processor drives the cache address, write data and write enable. Cache read data is returned to the selected processor through a per-processor holding register. The block sits between the processor cores and the cache RAM.

---
 rtl/mod_cache_mux.sv | 42 ++++
 tb/tb_mod_cache_mux.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mod_cache_mux.sv
// mod_cache_mux: two-processor arbitration mux onto one shared cache port.
// Writes are blocked during reset and during the cycle after an owner change.
module mod_cache_mux #(
    parameter int DW = 16,
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic [AW-1:0] proc1_Addr,
    input  logic [DW-1:0] proc1_DataIn,
    input  logic          proc1_WE,
    input  logic [AW-1:0] proc2_Addr,
    input  logic [DW-1:0] proc2_DataIn,
    input  logic          proc2_WE,
    input  logic [DW-1:0] cache_DataOut,
    output logic [AW-1:0] cache_Addr,
    output logic [DW-1:0] cache_DataIn,
    output logic          cache_WE,
    output logic [DW-1:0] proc1_DataOut,
    output logic [DW-1:0] proc2_DataOut
);
    logic sel_q;

    always_comb begin
        cache_Addr   = sel ? proc2_Addr : proc1_Addr;
        cache_DataIn = sel ? proc2_DataIn : proc1_DataIn;
        cache_WE     = !rst && (sel == sel_q) && (sel ? proc2_WE : proc1_WE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q         <= 1'b0;
            proc1_DataOut <= '0;
            proc2_DataOut <= '0;
        end else begin
            sel_q <= sel;
            if (sel) proc2_DataOut <= cache_DataOut;
            else     proc1_DataOut <= cache_DataOut;
        end
    end
endmodule

// File: tb/tb_mod_cache_mux.sv
// tb_mod_cache_mux: table-driven vectors plus toggle and random sequences,
// with registered read-return checked through a scoreboard queue.
module tb_mod_cache_mux;
    logic        clk = 1'b0;
    logic        rst, sel, proc1_WE, proc2_WE, cache_WE;
    logic [15:0] proc1_Addr, proc1_DataIn, proc2_Addr, proc2_DataIn, cache_DataOut;
    logic [15:0] cache_Addr, cache_DataIn, proc1_DataOut, proc2_DataOut;
    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic        rst, sel;
        logic [15:0] a1, d1;
        logic        w1;
        logic [15:0] a2, d2;
        logic        w2;
        logic [15:0] cdo, e_addr, e_din;
        logic        e_we;
        logic [15:0] e_p1, e_p2;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    logic        m_selq;
    logic [15:0] m_p1, m_p2;

    mod_cache_mux #(.DW(16), .AW(16)) dut (
        .clk(clk), .rst(rst), .sel(sel),
        .proc1_Addr(proc1_Addr), .proc1_DataIn(proc1_DataIn), .proc1_WE(proc1_WE),
        .proc2_Addr(proc2_Addr), .proc2_DataIn(proc2_DataIn), .proc2_WE(proc2_WE),
        .cache_DataOut(cache_DataOut), .cache_Addr(cache_Addr), .cache_DataIn(cache_DataIn),
        .cache_WE(cache_WE), .proc1_DataOut(proc1_DataOut), .proc2_DataOut(proc2_DataOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        @(negedge clk);
        rst = v.rst; sel = v.sel;
        proc1_Addr = v.a1; proc1_DataIn = v.d1; proc1_WE = v.w1;
        proc2_Addr = v.a2; proc2_DataIn = v.d2; proc2_WE = v.w2;
        cache_DataOut = v.cdo;
        sb.push_back(v);
        #1;
        chk("cache_Addr", cache_Addr, v.e_addr);
        chk("cache_DataIn", cache_DataIn, v.e_din);
        chk("cache_WE", {15'd0, cache_WE}, {15'd0, v.e_we});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("proc1_DataOut", proc1_DataOut, e.e_p1);
        chk("proc2_DataOut", proc2_DataOut, e.e_p2);
    endtask

    // Builds a vector whose expectations come from the behavioural model state.
    function automatic vec_t mk(input logic r, input logic s, input logic [15:0] a1, input logic [15:0] d1,
                                input logic w1, input logic [15:0] a2, input logic [15:0] d2,
                                input logic w2, input logic [15:0] cdo);
        vec_t v;
        v = '{r, s, a1, d1, w1, a2, d2, w2, cdo, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0};
        v.e_addr = s ? a2 : a1;
        v.e_din  = s ? d2 : d1;
        v.e_we   = !r && (s == m_selq) && (s ? w2 : w1);
        if (r) begin
            m_p1 = 16'h0; m_p2 = 16'h0; m_selq = 1'b0;
        end else begin
            if (s) m_p2 = cdo; else m_p1 = cdo;
            m_selq = s;
        end
        v.e_p1 = m_p1;
        v.e_p2 = m_p2;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; sel = 1'b0; proc1_WE = 1'b0; proc2_WE = 1'b0;
        proc1_Addr = 16'h0; proc1_DataIn = 16'h0; proc2_Addr = 16'h0; proc2_DataIn = 16'h0;
        cache_DataOut = 16'h0;
        repeat (2) @(posedge clk);
        //            rst  sel  a1        d1        w1   a2        d2        w2   cdo       addr      din       we   p1        p2
        vecs.push_back('{1'b1,1'b0,16'hFFFF,16'hFFFF,1'b1,16'h0000,16'h0000,1'b0,16'h0000,16'hFFFF,16'hFFFF,1'b0,16'h0000,16'h0000});
        vecs.push_back('{1'b0,1'b0,16'hFFFF,16'hFFFF,1'b1,16'h0000,16'h0000,1'b0,16'h0000,16'hFFFF,16'hFFFF,1'b1,16'h0000,16'h0000});
        vecs.push_back('{1'b0,1'b1,16'hFFFF,16'hFFFF,1'b1,16'h0000,16'h0000,1'b1,16'h0000,16'h0000,16'h0000,1'b0,16'h0000,16'h0000});
        vecs.push_back('{1'b0,1'b1,16'hFFFF,16'hFFFF,1'b1,16'h1111,16'h2222,1'b1,16'h0000,16'h1111,16'h2222,1'b1,16'h0000,16'h0000});
        vecs.push_back('{1'b0,1'b0,16'hFFFF,16'hFFFF,1'b1,16'h1111,16'h2222,1'b1,16'hA5A5,16'hFFFF,16'hFFFF,1'b0,16'hA5A5,16'h0000});
        vecs.push_back('{1'b0,1'b1,16'hFFFF,16'hFFFF,1'b1,16'h1111,16'h2222,1'b1,16'h1234,16'h1111,16'h2222,1'b0,16'hA5A5,16'h1234});
        vecs.push_back('{1'b0,1'b1,16'hFFFF,16'hFFFF,1'b1,16'h1111,16'h2222,1'b0,16'h5555,16'h1111,16'h2222,1'b0,16'hA5A5,16'h5555});
        vecs.push_back('{1'b0,1'b1,16'hFFFF,16'hFFFF,1'b1,16'h1111,16'h2222,1'b1,16'h5555,16'h1111,16'h2222,1'b1,16'hA5A5,16'h5555});
        vecs.push_back('{1'b1,1'b0,16'hFFFF,16'hFFFF,1'b1,16'h1111,16'h2222,1'b1,16'h9999,16'hFFFF,16'hFFFF,1'b0,16'h0000,16'h0000});
        vecs.push_back('{1'b0,1'b0,16'hFFFF,16'hFFFF,1'b1,16'h1111,16'h2222,1'b1,16'h0000,16'hFFFF,16'hFFFF,1'b1,16'h0000,16'h0000});
        vecs.push_back('{1'b1,1'b1,16'hFFFF,16'hFFFF,1'b1,16'h1111,16'h2222,1'b1,16'h7777,16'h1111,16'h2222,1'b0,16'h0000,16'h0000});
        vecs.push_back('{1'b0,1'b1,16'hFFFF,16'hFFFF,1'b1,16'h1111,16'h2222,1'b1,16'h7777,16'h1111,16'h2222,1'b0,16'h0000,16'h7777});
        vecs.push_back('{1'b0,1'b1,16'hFFFF,16'hFFFF,1'b0,16'h1111,16'h2222,1'b1,16'h7777,16'h1111,16'h2222,1'b1,16'h0000,16'h7777});
        vecs.push_back('{1'b0,1'b0,16'hFFFF,16'hFFFF,1'b0,16'h1111,16'h2222,1'b1,16'h0BAD,16'hFFFF,16'hFFFF,1'b0,16'h0BAD,16'h7777});
        vecs.push_back('{1'b0,1'b0,16'hFFFF,16'hFFFF,1'b0,16'h1111,16'h2222,1'b1,16'h0BAD,16'hFFFF,16'hFFFF,1'b0,16'h0BAD,16'h7777});
        vecs.push_back('{1'b0,1'b0,16'h0042,16'h00AB,1'b1,16'h1111,16'h2222,1'b1,16'h0BAD,16'h0042,16'h00AB,1'b1,16'h0BAD,16'h7777});
        foreach (vecs[i]) run_vec(vecs[i]);
        m_selq = 1'b0; m_p1 = 16'h0BAD; m_p2 = 16'h7777;
        // Toggling owner every cycle must never let a write through.
        for (int i = 0; i < 10; i++)
            run_vec(mk(1'b0, (i % 2) == 0, 16'h0100 + 16'(i), 16'hC000 + 16'(i), 1'b1,
                       16'h0200 + 16'(i), 16'hD000 + 16'(i), 1'b1, 16'hE000 + 16'(i)));
        for (int i = 0; i < 60; i++)
            run_vec(mk($urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
                       16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                       16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
